// File: rtl/calc_pkg.sv
// Shared calculator types: operand selector mode encoding.
package calc_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } calc_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned  NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    localparam logic [SEL_W:0] NumChW = (SEL_W+1)'(NUM_CH);

    // One extra bit so ptr+offset can exceed NUM_CH-1 before the wrap subtract.
    logic [SEL_W:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(off);
            if (cand >= NumChW) begin
                cand = cand - NumChW;
            end
            if (!gnt_valid && req[cand[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/operand_mux_reg.sv
// N-channel registered result selector with manual or round-robin arbitration
// and valid/ready handshakes on every input and on the output.
module operand_mux_reg import calc_pkg::*; #(
    parameter int unsigned  WIDTH  = 4,
    parameter int unsigned  NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sel
);

    localparam logic [SEL_W:0]   NumChW = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             err_sel_q, err_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    calc_mode_t       mode_e;
    logic             sel_ok;
    logic             rr_gnt_valid;
    logic [SEL_W-1:0] rr_gnt_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic             load;
    logic             xfer;

    assign mode_e = calc_mode_t'(mode);
    assign sel_ok = ({1'b0, sel} < NumChW);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        case (mode_e)
            MODE_RR: begin
                gnt_valid = rr_gnt_valid;
                gnt_idx   = rr_gnt_idx;
            end
            default: begin
                gnt_valid = sel_ok && in_valid[sel];
                gnt_idx   = sel;
            end
        endcase
    end

    assign load = !out_valid_q || out_ready;
    // rst_n gates acceptance so nothing is consumed upstream on a reset cycle.
    assign xfer = load && rst_n && gnt_valid;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        err_sel_d   = err_sel_q || (mode_e == MODE_MANUAL && !sel_ok);
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = in_data[gnt_idx*WIDTH +: WIDTH];
                out_ch_d   = gnt_idx;
            end
        end
        if (xfer && mode_e == MODE_RR) begin
            ptr_d = (gnt_idx == LastCh) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            err_sel_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            err_sel_q   <= err_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_operand_mux_reg.sv
// Bench for operand_mux_reg: directed scenarios plus randomized traffic against a reference model.
module tb_operand_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        err_sel;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [3:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;
    logic        err_sel3;

    int errors = 0;
    int checks = 0;

    // Reference model state for the 4-channel instance
    bit         m_valid;
    logic [3:0] m_data;
    int         m_ch;
    int         m_ptr;
    bit         m_err;

    operand_mux_reg #(
        .WIDTH  (4),
        .NUM_CH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    operand_mux_reg #(
        .WIDTH  (4),
        .NUM_CH (3)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .err_sel   (err_sel3)
    );

    function automatic void mgrant(input logic md, input int s, input logic [3:0] v,
                                   input int p, output bit gv, output int gi);
        gv = 1'b0;
        gi = 0;
        if (md == 1'b0) begin
            if (s < 4 && v[s] === 1'b1) begin
                gv = 1'b1;
                gi = s;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (p + k) % 4;
                if (!gv && v[c] === 1'b1) begin
                    gv = 1'b1;
                    gi = c;
                end
            end
        end
    endfunction

    function automatic logic [3:0] m_ready();
        bit gv;
        int gi;
        mgrant(mode, int'(sel), in_valid, m_ptr, gv, gi);
        if (rst_n && (!m_valid || out_ready) && gv) return 4'(1 << gi);
        return 4'b0000;
    endfunction

    // Advance one clock and step the model with the inputs present at the edge
    task automatic tick();
        bit gv;
        int gi;
        bit ld;
        mgrant(mode, int'(sel), in_valid, m_ptr, gv, gi);
        ld = !m_valid || out_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 4'h0;
            m_ch    = 0;
            m_ptr   = 0;
            m_err   = 1'b0;
        end else begin
            if (ld) begin
                if (gv) begin
                    m_valid = 1'b1;
                    m_data  = in_data[gi*4 +: 4];
                    m_ch    = gi;
                    if (mode) m_ptr = (gi + 1) % 4;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (!mode && int'(sel) >= 4) m_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
        in_data = 16'($urandom);
        in_valid3 = 3'b000; in_data3 = 12'h0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        repeat (2) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
            end
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0) begin
                errors++;
                $display("FAIL reset_out: got valid=%b data=%h ch=%0d expected 0/0/0",
                         out_valid, out_data, out_ch);
            end
            checks++;
            if (err_sel !== 1'b0 || err_sel3 !== 1'b0) begin
                errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err_sel, err_sel3);
            end
        end
    endtask

    task automatic test_manual();
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = 16'($urandom);
        in_data[11:8] = 4'hA;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL manual_in_ready: got %b expected 0100", in_ready);
        end
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL manual_out: got valid=%b data=%h ch=%0d expected 1/a/2",
                     out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data[11:8] = 4'h5;
        repeat (3) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_in_ready: got %b expected 0000", in_ready);
            end
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'hA) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b data=%h expected 1/a", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
        end
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h5) begin
            errors++;
            $display("FAIL bp_release_out: got valid=%b data=%h expected 1/5", out_valid, out_data);
        end
    endtask

    task automatic test_rr_fair();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) in_data[k*4 +: 4] = 4'(k + 1);
        for (int i = 0; i < 5; i++) begin
            int exp_ch;
            exp_ch = i % 4;
            #1;
            checks++;
            if (in_ready !== 4'(1 << exp_ch)) begin
                errors++;
                $display("FAIL rr_fair_ready[%0d]: got %b expected %b", i, in_ready,
                         4'(1 << exp_ch));
            end
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(exp_ch) || out_data !== 4'(exp_ch + 1)) begin
                errors++;
                $display("FAIL rr_fair_out[%0d]: got valid=%b ch=%0d data=%h expected 1/%0d/%0d",
                         i, out_valid, out_ch, out_data, exp_ch, exp_ch + 1);
            end
        end
    endtask

    task automatic test_rr_skip_mode();
        int seq[3] = '{1, 3, 1};
        rst_n = 1'b0; in_valid = 4'b0000;
        tick();
        #1;
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        in_data = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'(1 << seq[i])) begin
                errors++;
                $display("FAIL rr_skip_ready[%0d]: got %b expected %b", i, in_ready,
                         4'(1 << seq[i]));
            end
            tick();
            #1;
            checks++;
            if (out_ch !== 2'(seq[i]) || out_data !== in_data[seq[i]*4 +: 4]) begin
                errors++;
                $display("FAIL rr_skip_out[%0d]: got ch=%0d data=%h expected %0d/%h", i, out_ch,
                         out_data, seq[i], in_data[seq[i]*4 +: 4]);
            end
        end
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL switch_manual_ready: got %b expected 0001", in_ready);
        end
        tick();
        #1;
        checks++;
        if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL switch_manual_out: got ch=%0d valid=%b expected 0/1", out_ch, out_valid);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++; $display("FAIL switch_rr_ready: got %b expected 1000", in_ready);
        end
        tick();
        #1;
        checks++;
        if (out_ch !== 2'd3) begin
            errors++; $display("FAIL switch_rr_out: got ch=%0d expected 3", out_ch);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst_n     = ($urandom_range(0, 24) != 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
            end
            tick();
            #1;
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)
                || err_sel !== m_err) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d e=%b expected %b/%h/%0d/%b", i,
                         out_valid, out_data, out_ch, err_sel, m_valid, m_data, m_ch, m_err);
            end
        end
    endtask

    task automatic test_invalid_sel();
        rst_n = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = 12'($urandom);
        tick();
        #1;
        checks++;
        if (out_valid3 !== 1'b1 || err_sel3 !== 1'b0) begin
            errors++;
            $display("FAIL inv_pre: got valid=%b err=%b expected 1/0", out_valid3, err_sel3);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            errors++; $display("FAIL inv_ready: got %b expected 000", in_ready3);
        end
        tick();
        #1;
        checks++;
        if (out_valid3 !== 1'b0 || err_sel3 !== 1'b1) begin
            errors++;
            $display("FAIL inv_out: got valid=%b err=%b expected 0/1", out_valid3, err_sel3);
        end
        sel3 = 2'd0;
        #1;
        checks++;
        if (in_ready3 !== 3'b001) begin
            errors++; $display("FAIL inv_recover_ready: got %b expected 001", in_ready3);
        end
        tick();
        #1;
        checks++;
        if (err_sel3 !== 1'b1 || out_valid3 !== 1'b1 || out_ch3 !== 2'd0
            || out_data3 !== in_data3[3:0]) begin
            errors++;
            $display("FAIL inv_sticky: got err=%b valid=%b ch=%0d data=%h expected 1/1/0/%h",
                     err_sel3, out_valid3, out_ch3, out_data3, in_data3[3:0]);
        end
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if (err_sel3 !== 1'b0 || out_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL inv_reset: got err=%b valid=%b expected 0/0", err_sel3, out_valid3);
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_data  = 4'h0;
        m_ch    = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        test_reset();
        test_manual();
        test_backpressure();
        test_rr_fair();
        test_rr_skip_mode();
        test_random();
        test_invalid_sel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_mux_reg.md
# operand_mux_reg

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the calculator's 1-bit 2:1 select into an arbitrated result selector that sits between the ALU result channels and the display/result register.
- **Manual mode** forwards the channel chosen by `sel`.
- **Round-robin mode** scans the pending channels fairly.
- Output is registered and back-pressurable.

## Interface
- `WIDTH`, default 4: data width per channel.
- `NUM_CH`, default 4: channel count, ≥2. `SEL_W = $clog2(NUM_CH)` is a derived localparam, not overridable.
- `clk` — in, 1 — the single clock; all state updates on the rising edge.
- `rst_n` — in, 1 — synchronous, active-low reset.
- `in_data` — in, NUM_CH*WIDTH — channel k at `[k*WIDTH +: WIDTH]`.
- `in_valid` — in, NUM_CH — per-channel data valid.
- `in_ready` — out, NUM_CH — per-channel accept, combinational.
- `mode` — in, 1 — 0 = manual, 1 = round-robin.
- `sel` — in, SEL_W — channel index, used only in manual mode.
- `out_data` — out, WIDTH — registered selected data.
- `out_ch` — out, SEL_W — index of the channel that produced `out_data`.
- `out_valid` — out, 1 — output register holds data.
- `out_ready` — in, 1 — downstream accept.
- `err_sel` — out, 1 — sticky; set when manual `sel` ≥ NUM_CH.

## Operation
- `load = !out_valid || out_ready`: the output register can accept new data this cycle.
- **Grant, manual mode:** grant channel `sel` iff `sel < NUM_CH` and `in_valid[sel]`.
- **Grant, round-robin mode:** grant the first k with `in_valid[k]`, searching from `ptr` upward and wrapping past NUM_CH-1 to 0.
- **in_ready:** `in_ready[k] = load && grant==k && rst_n`. At most one bit is set. All bits are 0 while `rst_n` is low.
- **Transfer:** `in_valid[k] && in_ready[k]`. On transfer, `out_data <= in_data[k]`, `out_ch <= k`, `out_valid <= 1`.
- **No transfer, load=1:** `out_valid <= 0`; `out_data`/`out_ch` hold their last values.
- **No transfer, load=0:** all output registers hold.
- **Round-robin pointer:** `ptr` (SEL_W bits) advances only on a round-robin transfer, to `grant+1`, wrapping NUM_CH-1 → 0. Manual transfers do not move `ptr`.
- **Mode switch:**
  - `mode` is sampled every cycle and takes effect on the same cycle's grant.
  - `ptr` is retained across mode switches.
  - A held output (`out_valid=1`, `out_ready=0`) is not disturbed.
- **err_sel:** set on any cycle with `mode=0 && sel>=NUM_CH`. It stays set until reset. No transfer occurs for that `sel`. This can only happen when NUM_CH is not a power of 2.
- **Reset values:** `out_data=0`, `out_ch=0`, `out_valid=0`, `err_sel=0`, `ptr=0`.
- **Reset mid-operation:** data held in the output register is discarded, and no input is accepted on the reset cycle.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`/`out_data`.
- Throughput: one transfer per cycle when `out_ready=1` continuously. There are no bubbles.
- **Back-pressure:** when `out_valid=1` and `out_ready=0`, all `in_ready` bits are 0 and the output is stable.
- **Pop and push in the same cycle:** when `out_valid=1` and `out_ready=1` and a grant exists, the output is replaced with no idle cycle.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel` and `ptr`. There is no combinational path from any input to `out_*`.
- Inputs must not depend combinationally on `in_ready`.

## Structure
- Shared package `calc_pkg`:
  - `MODE_MANUAL = 1'b0`, `MODE_RR = 1'b1`.
  - A `calc_mode_t` typedef.
- Sub-module `rr_arbiter`:
  - Parameter `NUM_CH`.
  - Inputs: `req[NUM_CH]`, `ptr[SEL_W]`.
  - Outputs: `gnt_valid`, `gnt_idx[SEL_W]`.
  - Purely combinational.
- The top level contains `ptr`, the output register, `err_sel`, the manual/round-robin grant mux and `in_ready` generation.

## Test plan
All scenarios use WIDTH=4 and NUM_CH=4 unless stated.
- **Reset:** hold `rst_n=0` for 2 cycles with `in_valid=1111`, `out_ready=1` → `out_valid=0`, `out_data=0`, `out_ch=0`, `in_ready=0000`, `err_sel=0`.
- **Manual forward:** `mode=0`, `sel=2`, `in_valid=0100`, channel 2 = 4'hA, `out_ready=1` → `in_ready=0100` that cycle; next cycle `out_valid=1`, `out_data=A`, `out_ch=2`.
- **Back-pressure:** with `out_valid=1` holding A, set `out_ready=0` for 3 cycles and change channel 2 to 5 → `in_ready=0000` and `out_data=A` for all 3 cycles. On `out_ready=1`, 5 is accepted and appears one cycle later.
- **Round-robin fairness:** `mode=1`, `in_valid=1111`, channel k = k+1, `out_ready=1` continuously → `out_ch` sequence 0,1,2,3,0 and `out_data` 1,2,3,4,1, with `out_valid=1` every cycle.
- **Round-robin skip and mode switch:**
  - With `ptr=0` and `in_valid=1010` → `out_ch` sequence 1,3,1.
  - Then switch to `mode=0`, `sel=0`, `in_valid=1011` → channel 0 is granted; `ptr` is unchanged on return to `mode=1` (next grant is channel 3).
- **Invalid select:** NUM_CH=3, `mode=0`, `sel=3`, `in_valid=111` → `in_ready=000`, `out_valid` falls to 0, `err_sel=1`. `err_sel` stays 1 after `sel=0`, until `rst_n=0`.
